// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and widths used by the register file, the ID/EX rt-rd mux and the
// pipeline registers.
package cpu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned PEND_W   = 2;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_num_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [PEND_W-1:0] pend_t;

  localparam reg_num_t REG_ZERO = '0;
  localparam pend_t    PEND_MAX = '1;
  localparam pend_t    PEND_ONE = pend_t'(1);

endpackage

// File: rtl/reg_file_wb_if.sv
// Bundle between ID / MEM-WB (master) and the write-back register file (slave).
interface reg_file_wb_if;
  import cpu_pkg::*;

  reg_num_t rs_addr;
  reg_num_t rt_addr;
  word_t    rs_data;
  word_t    rt_data;
  logic     id_issue;
  reg_num_t id_dst;
  logic     wb_regwrite;
  reg_num_t wb_dst;
  word_t    wb_data;
  logic     stall;
  logic     pend_full;

  modport master (
    output rs_addr, rt_addr, id_issue, id_dst, wb_regwrite, wb_dst, wb_data,
    input  rs_data, rt_data, stall, pend_full
  );

  modport slave (
    input  rs_addr, rt_addr, id_issue, id_dst, wb_regwrite, wb_dst, wb_data,
    output rs_data, rt_data, stall, pend_full
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters: raise on ID issue, lower on write-back commit, and flag
// RAW stalls and counter saturation to ID.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  reg_num_t rs_addr,
  input  reg_num_t rt_addr,
  input  logic     id_issue,
  input  reg_num_t id_dst,
  input  logic     wb_regwrite,
  input  reg_num_t wb_dst,
  output logic     stall,
  output logic     pend_full
);

  pend_t pend_q [NUM_REGS];
  pend_t pend_d [NUM_REGS];
  logic  inc, dec, bypass_rs, bypass_rt;

  // pend_q[0] is never incremented or decremented, so it stays at its reset value of zero.
  always_comb begin
    pend_full = id_issue && (pend_q[id_dst] == PEND_MAX);
    inc       = id_issue && (id_dst != REG_ZERO) && !pend_full;
    dec       = wb_regwrite && (wb_dst != REG_ZERO) && (pend_q[wb_dst] != '0);
    bypass_rs = wb_regwrite && (wb_dst == rs_addr) && (pend_q[rs_addr] == PEND_ONE);
    bypass_rt = wb_regwrite && (wb_dst == rt_addr) && (pend_q[rt_addr] == PEND_ONE);
    stall     = ((pend_q[rs_addr] != '0) && !bypass_rs) ||
                ((pend_q[rt_addr] != '0) && !bypass_rt);
  end

  always_comb begin
    pend_d = pend_q;
    // Issue and commit to the same register cancel out.
    if (!(inc && dec && (id_dst == wb_dst))) begin
      if (inc) pend_d[id_dst] = pend_q[id_dst] + PEND_ONE;
      if (dec) pend_d[wb_dst] = pend_q[wb_dst] - PEND_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) pend_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// 32x32 register file at the write-back end of the pipeline: one write port from MEM/WB, two
// combinational write-first read ports for ID, plus the RAW-hazard scoreboard.
module reg_file_wb
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  reg_file_wb_if.slave  bus
);

  word_t regs_q [NUM_REGS];
  logic  wr_en;

  assign wr_en = bus.wb_regwrite && (bus.wb_dst != REG_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[bus.wb_dst] <= bus.wb_data;
    end
  end

  // Write-first: a commit in flight this cycle wins over the stored value.
  always_comb begin
    bus.rs_data = regs_q[bus.rs_addr];
    bus.rt_data = regs_q[bus.rt_addr];
    if (bus.rs_addr == REG_ZERO)                   bus.rs_data = '0;
    else if (wr_en && (bus.wb_dst == bus.rs_addr)) bus.rs_data = bus.wb_data;
    if (bus.rt_addr == REG_ZERO)                   bus.rt_data = '0;
    else if (wr_en && (bus.wb_dst == bus.rt_addr)) bus.rt_data = bus.wb_data;
  end

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs_addr     (bus.rs_addr),
    .rt_addr     (bus.rt_addr),
    .id_issue    (bus.id_issue),
    .id_dst      (bus.id_dst),
    .wb_regwrite (bus.wb_regwrite),
    .wb_dst      (bus.wb_dst),
    .stall       (bus.stall),
    .pend_full   (bus.pend_full)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios with literal expectations plus random
// traffic compared every cycle against an array/count model of the register file.
module tb_reg_file_wb;

  typedef int pend_arr_t [32];

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  logic [31:0] m_regs [32];
  pend_arr_t   m_pend;

  reg_file_wb_if bus ();

  reg_file_wb u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_regwrite && bus.wb_dst == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic logic busy(input logic [4:0] a);
    return (m_pend[a] != 0) && !(bus.wb_regwrite && bus.wb_dst == a && m_pend[a] == 1);
  endfunction

  function automatic logic exp_full();
    return bus.id_issue && (m_pend[bus.id_dst] == 3);
  endfunction

  function automatic pend_arr_t next_pend();
    pend_arr_t np = m_pend;
    if (bus.id_issue && bus.id_dst != 5'd0 && !exp_full()) np[bus.id_dst] += 1;
    if (bus.wb_regwrite && bus.wb_dst != 5'd0 && m_pend[bus.wb_dst] > 0) np[bus.wb_dst] -= 1;
    return np;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_regs <= '{default: 32'd0};
      m_pend <= '{default: 0};
    end else begin
      if (bus.wb_regwrite && bus.wb_dst != 5'd0) m_regs[bus.wb_dst] <= bus.wb_data;
      m_pend <= next_pend();
    end
  end

  always @(negedge clk) begin
    check("rs_data", bus.rs_data, exp_read(bus.rs_addr));
    check("rt_data", bus.rt_data, exp_read(bus.rt_addr));
    check("stall", {31'd0, bus.stall}, {31'd0, busy(bus.rs_addr) || busy(bus.rt_addr)});
    check("pend_full", {31'd0, bus.pend_full}, {31'd0, exp_full()});
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_issue    = 1'b0;
    bus.wb_regwrite = 1'b0;
    bus.id_dst      = 5'd0;
    bus.wb_dst      = 5'd0;
    bus.wb_data     = 32'd0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    idle();
    #1 rst_n = 1'b0;

    // Reset: all registers read zero, no stall.
    cyc();
    for (int r = 1; r < 32; r++) begin
      bus.rs_addr = 5'(r);
      bus.rt_addr = 5'(32 - r);
      #1;
      check("reset_rs", bus.rs_data, 32'd0);
      check("reset_rt", bus.rt_data, 32'd0);
    end
    check("reset_stall", {31'd0, bus.stall}, 32'd0);

    // Release mid-cycle, issue to r5, then reset asynchronously.
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    bus.id_issue = 1'b1;
    bus.id_dst   = 5'd5;
    bus.rs_addr  = 5'd5;
    bus.rt_addr  = 5'd0;
    cyc();
    idle();
    #1 check("issue_r5_stall", {31'd0, bus.stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_stall", {31'd0, bus.stall}, 32'd0);
    #1 rst_n = 1'b1;

    // Write/read with same-cycle bypass and next-cycle array read.
    cyc();
    bus.wb_regwrite = 1'b1;
    bus.wb_dst      = 5'd8;
    bus.wb_data     = 32'hDEADBEEF;
    bus.rs_addr     = 5'd8;
    bus.rt_addr     = 5'd8;
    #1 check("bypass_r8", bus.rs_data, 32'hDEADBEEF);
    cyc();
    idle();
    #1 check("array_r8", bus.rs_data, 32'hDEADBEEF);
    check("array_r8_rt", bus.rt_data, 32'hDEADBEEF);

    // R0 guard.
    cyc();
    bus.wb_regwrite = 1'b1;
    bus.wb_dst      = 5'd0;
    bus.wb_data     = 32'hFFFFFFFF;
    bus.rs_addr     = 5'd0;
    #1 check("r0_bypass", bus.rs_data, 32'd0);
    cyc();
    idle();
    #1 check("r0_array", bus.rs_data, 32'd0);
    check("r0_stall", {31'd0, bus.stall}, 32'd0);

    // RAW stall on r10, cleared by its commit.
    cyc();
    bus.id_issue = 1'b1;
    bus.id_dst   = 5'd10;
    cyc();
    idle();
    bus.rs_addr = 5'd10;
    #1 check("raw_stall", {31'd0, bus.stall}, 32'd1);
    cyc();
    bus.wb_regwrite = 1'b1;
    bus.wb_dst      = 5'd10;
    bus.wb_data     = 32'h12345678;
    #1 check("raw_commit_stall", {31'd0, bus.stall}, 32'd0);
    check("raw_commit_data", bus.rs_data, 32'h12345678);
    cyc();
    idle();
    #1 check("raw_after_stall", {31'd0, bus.stall}, 32'd0);

    // Simultaneous issue + commit on r3 keeps count at 1.
    cyc();
    bus.id_issue = 1'b1;
    bus.id_dst   = 5'd3;
    bus.rs_addr  = 5'd3;
    cyc();
    bus.wb_regwrite = 1'b1;
    bus.wb_dst      = 5'd3;
    bus.wb_data     = 32'h00003333;
    #1 check("sim_full", {31'd0, bus.pend_full}, 32'd0);
    cyc();
    idle();
    #1 check("sim_stall_persists", {31'd0, bus.stall}, 32'd1);
    cyc();
    bus.wb_regwrite = 1'b1;
    bus.wb_dst      = 5'd3;
    cyc();
    idle();
    #1 check("sim_cleared", {31'd0, bus.stall}, 32'd0);

    // Saturation on r7, drain, then commit at zero must not underflow.
    bus.rs_addr = 5'd7;
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.id_issue = 1'b1;
      bus.id_dst   = 5'd7;
      #1 check("sat_not_full", {31'd0, bus.pend_full}, 32'd0);
    end
    cyc();
    #1 check("sat_full", {31'd0, bus.pend_full}, 32'd1);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.wb_regwrite = 1'b1;
      bus.wb_dst      = 5'd7;
      bus.wb_data     = 32'h70 + 32'(i);
      #1 check("sat_drain_stall", {31'd0, bus.stall}, (i < 2) ? 32'd1 : 32'd0);
      cyc();
    end
    idle();
    #1 check("sat_drained", {31'd0, bus.stall}, 32'd0);
    bus.wb_regwrite = 1'b1;
    bus.wb_dst      = 5'd7;
    cyc();
    idle();
    bus.id_issue = 1'b1;
    bus.id_dst   = 5'd7;
    #1 check("no_underflow_full", {31'd0, bus.pend_full}, 32'd0);
    cyc();
    idle();
    #1 check("no_underflow_stall", {31'd0, bus.stall}, 32'd1);
    bus.wb_regwrite = 1'b1;
    bus.wb_dst      = 5'd7;
    cyc();
    idle();
    #1 check("no_underflow_clear", {31'd0, bus.stall}, 32'd0);

    // Random traffic over a narrow register window to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      cyc();
      bus.rs_addr     = 5'($urandom_range(0, 7));
      bus.rt_addr     = 5'($urandom_range(0, 7));
      bus.id_issue    = ($urandom_range(0, 2) == 0);
      bus.id_dst      = 5'($urandom_range(0, 7));
      bus.wb_regwrite = ($urandom_range(0, 2) == 0);
      bus.wb_dst      = 5'($urandom_range(0, 7));
      bus.wb_data     = $urandom;
      if (i % 500 == 499) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    cyc();
    idle();
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
